// File: rtl/delay_line_pkg.sv
// delay_line_pkg: default timing constants, FSM states and counter-width helper for delay_line_mc
package delay_line_pkg;
  localparam int DEF_DEPTH        = 576;
  localparam int DEF_BIT_CYCLES   = 162;
  localparam int DEF_PULSE_CYCLES = 73;
  localparam int DEF_MOD_HALF     = 3;
  typedef enum logic [1:0] {PRIME, RUN, CLEAR} state_t;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/delay_line_ram.sv
// delay_line_ram: DEPTH x CHANNELS simple dual-port RAM, synchronous write, registered read
module delay_line_ram #(
  parameter int DEPTH    = 576,
  parameter int CHANNELS = 4,
  parameter int AW       = 10
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [CHANNELS-1:0] wdata,
  input  logic [AW-1:0]       raddr,
  output logic [CHANNELS-1:0] rdata
);
  logic [CHANNELS-1:0] mem_q [DEPTH];
  // storage array, no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata <= mem_q[raddr];
  end
endmodule

// File: rtl/delay_line_mc.sv
// delay_line_mc: multi-channel mercury-tank delay line with recirculation, clear and priming
module delay_line_mc
  import delay_line_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int MOD_HALF     = DEF_MOD_HALF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in_sig,
  input  logic [CHANNELS-1:0] recirc,
  input  logic                clear,
  output logic [CHANNELS-1:0] out_sig,
  output logic [CHANNELS-1:0] out_en,
  output logic                slot_start,
  output logic                busy
);
  localparam int CW = cnt_w(BIT_CYCLES);
  localparam int AW = cnt_w(DEPTH);
  localparam int MW = cnt_w(MOD_HALF);
  localparam logic [CW-1:0] CYC_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CYC_ONE   = CW'(1);
  localparam logic [CW-1:0] CYC_PULSE = CW'(PULSE_CYCLES);
  localparam logic [AW-1:0] IDX_LAST  = AW'(DEPTH - 1);
  localparam logic [MW-1:0] MOD_LAST  = MW'(MOD_HALF - 1);

  if (PULSE_CYCLES + 2 >= BIT_CYCLES) begin : g_bad_pulse
    $error("PULSE_CYCLES+2 must be less than BIT_CYCLES");
  end
  if (MOD_HALF < 1) begin : g_bad_mod
    $error("MOD_HALF must be at least 1");
  end

  logic [CW-1:0]       cyc_q, cyc_d;
  logic [AW-1:0]       idx_q, idx_d, cnt_q, cnt_d;
  state_t              state_q, state_d;
  logic                clr_q, clr_d, slot_q, slot_d, car_q, car_d;
  logic [MW-1:0]       mod_q, mod_d;
  logic [CHANNELS-1:0] sync1_q, sync2_q, seen_q, seen_d, bit_q, bit_d;
  logic [CHANNELS-1:0] out_sig_q, out_sig_d, out_en_q, out_en_d, wdata, rdata;
  logic                wrap, in_burst;

  delay_line_ram #(.DEPTH(DEPTH), .CHANNELS(CHANNELS), .AW(AW)) u_ram (
    .clk(clk), .we(wrap), .waddr(idx_q), .wdata(wdata), .raddr(idx_q), .rdata(rdata)
  );

  // slot timing, clear latch and PRIME/RUN/CLEAR sequencing; state only moves at slot boundaries
  always_comb begin
    wrap    = cyc_q == CYC_LAST;
    cyc_d   = wrap ? '0 : cyc_q + 1'b1;
    idx_d   = !wrap ? idx_q : (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    slot_d  = wrap;
    clr_d   = state_q == RUN && !wrap && (clr_q || clear);
    state_d = !wrap ? state_q : (state_q == RUN) ? ((clr_q || clear) ? CLEAR : RUN)
            : (cnt_q == IDX_LAST) ? RUN : state_q;
    cnt_d   = !wrap ? cnt_q : (state_q == RUN || cnt_q == IDX_LAST) ? '0 : cnt_q + 1'b1;
  end

  // per-channel capture, write-back selection and burst modulation; outputs are registered one cycle ahead
  always_comb begin
    seen_d    = (cyc_q == '0 ? '0 : seen_q) | sync2_q;
    bit_d     = cyc_q == CYC_ONE ? rdata : bit_q;
    wdata     = state_q == CLEAR ? '0
              : (recirc & (state_q == PRIME ? '0 : bit_q)) | (~recirc & seen_d);
    car_d     = cyc_q == CYC_ONE ? 1'b1 : (mod_q == MOD_LAST ? ~car_q : car_q);
    mod_d     = (cyc_q == CYC_ONE || mod_q == MOD_LAST) ? '0 : mod_q + 1'b1;
    in_burst  = state_q == RUN && cyc_q >= CYC_ONE && cyc_q <= CYC_PULSE;
    out_en_d  = in_burst ? bit_d : '0;
    out_sig_d = out_en_d & {CHANNELS{car_d}};
  end

  // all state registers; async reset drops the pad outputs immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      state_q   <= PRIME;
      clr_q     <= 1'b0;
      slot_q    <= 1'b0;
      car_q     <= 1'b0;
      mod_q     <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      seen_q    <= '0;
      bit_q     <= '0;
      out_sig_q <= '0;
      out_en_q  <= '0;
    end else begin
      cyc_q     <= cyc_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      clr_q     <= clr_d;
      slot_q    <= slot_d;
      car_q     <= car_d;
      mod_q     <= mod_d;
      sync1_q   <= in_sig;
      sync2_q   <= sync1_q;
      seen_q    <= seen_d;
      bit_q     <= bit_d;
      out_sig_q <= out_sig_d;
      out_en_q  <= out_en_d;
    end
  end

  assign out_sig    = out_sig_q;
  assign out_en     = out_en_q;
  assign slot_start = slot_q;
  assign busy       = state_q != RUN;
endmodule

// File: tb/tb_delay_line_mc.sv
// tb_delay_line_mc: slot-level reference model plus table and corner-case sequences for delay_line_mc
module tb_delay_line_mc;
  localparam int CH = 4, DEPTH = 8, BC = 24, PC = 9, MH = 2, NS = 512;
  localparam int M_PRIME = 0, M_RUN = 1, M_CLR = 2;

  typedef struct {
    logic [CH-1:0] mask;
    int            pos;
    int            len;
    logic [CH-1:0] e0;
    logic [CH-1:0] e1;
  } vec_t;

  logic clk = 0, rst_n = 0, clear = 0;
  logic [CH-1:0] in_sig = '0, recirc = '0, out_sig, out_en;
  logic slot_start, busy;

  delay_line_mc #(.CHANNELS(CH), .DEPTH(DEPTH), .BIT_CYCLES(BC), .PULSE_CYCLES(PC), .MOD_HALF(MH)) dut (
    .clk(clk), .rst_n(rst_n), .in_sig(in_sig), .recirc(recirc), .clear(clear),
    .out_sig(out_sig), .out_en(out_en), .slot_start(slot_start), .busy(busy)
  );

  always #5 clk = ~clk;

  int t, n_pass, n_tot, busy_cnt, first_sig0;
  int rise_cnt [CH];
  int en_cnt [CH];
  logic [CH-1:0] pin_v, rc_v, prev_en, prev_sig;
  logic clr_v;
  logic [CH-1:0] seen_m [NS];
  logic [CH-1:0] stored [NS];
  logic [CH-1:0] tv_exp [NS];
  logic tv_valid [NS];
  int mode [NS];
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_tot++;
    if (a !== e) $display("FAIL %s t=%0d got %h want %h", nm, t, a, e);
    else n_pass++;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin
      seen_m[i] = '0; stored[i] = '0; tv_exp[i] = '0; tv_valid[i] = 0;
      mode[i] = (i < DEPTH) ? M_PRIME : M_RUN;
    end
    t = 0;
  endfunction

  function automatic void trk_reset();
    for (int i = 0; i < CH; i++) begin rise_cnt[i] = 0; en_cnt[i] = 0; end
    busy_cnt = 0; first_sig0 = -1; prev_en = out_en; prev_sig = out_sig;
  endfunction

  function automatic int en_total();
    int s = 0;
    for (int i = 0; i < CH; i++) s += en_cnt[i];
    return s;
  endfunction

  // one clock cycle: drive inputs, compare against the model, then advance the model
  task automatic tick();
    int n, c, land;
    logic [CH-1:0] e_en, e_sig, old;
    n = t / BC;
    c = t % BC;
    if (n >= NS - DEPTH - 1) begin
      $display("FAIL model_range t=%0d", t);
      $fatal(1);
    end
    in_sig = pin_v; recirc = rc_v; clear = clr_v;
    old = (n >= DEPTH) ? stored[n - DEPTH] : '0;
    e_en = (mode[n] == M_RUN && c >= 2 && c <= PC + 1) ? old : '0;
    e_sig = (((c - 2) / MH) % 2 == 0) ? e_en : '0;
    chk("outputs", {out_sig, out_en, slot_start, busy},
        {e_sig, e_en, (c == 0 && n > 0), (mode[n] != M_RUN)});
    if (c == 2 && tv_valid[n]) chk("table_en", out_en, tv_exp[n]);
    for (int i = 0; i < CH; i++) begin
      if (out_en[i] && !prev_en[i]) rise_cnt[i]++;
      if (out_en[i]) en_cnt[i]++;
    end
    if (out_sig[0] && !prev_sig[0] && first_sig0 < 0) first_sig0 = t;
    if (busy) busy_cnt++;
    prev_en = out_en; prev_sig = out_sig;
    land = (t + 2) / BC;
    seen_m[land] |= pin_v;
    if (clr_v && mode[n] == M_RUN)
      for (int k = n + 1; k <= n + DEPTH; k++) mode[k] = M_CLR;
    if (c == BC - 1)
      for (int i = 0; i < CH; i++)
        stored[n][i] = (mode[n] == M_CLR) ? 1'b0
                     : rc_v[i] ? (mode[n] == M_PRIME ? 1'b0 : old[i]) : seen_m[n][i];
    @(negedge clk);
    t++;
  endtask

  task automatic run_slots(input int k);
    repeat (k * BC) tick();
  endtask

  task automatic align();
    while (t % BC != 0) tick();
  endtask

  initial begin
    int s, u, g;
    int pos [CH];
    int len [CH];
    logic b [CH];
    logic [34:0] wd;
    tbl[0] = '{4'b0001, 0,      1, 4'b0001, 4'b0000};
    tbl[1] = '{4'b0110, BC - 3, 1, 4'b0110, 4'b0000};
    tbl[2] = '{4'b1000, BC - 2, 1, 4'b0000, 4'b1000};
    tbl[3] = '{4'b1111, BC - 1, 1, 4'b0000, 4'b1111};
    tbl[4] = '{4'b0101, 7,      3, 4'b0101, 4'b0000};
    tbl[5] = '{4'b1010, BC - 3, 4, 4'b1010, 4'b1010};
    n_pass = 0; n_tot = 0; t = 0;
    pin_v = '0; rc_v = '0; clr_v = 0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {out_sig, out_en, slot_start}, 0);
    chk("reset_busy", busy, 1);
    rst_n = 1;
    model_reset(); trk_reset();
    run_slots(DEPTH);
    chk("prime_len", busy_cnt, DEPTH * BC);
    chk("prime_quiet", en_total(), 0);
    chk("busy_fall", busy, 0);

    for (int k = 0; k < 6; k++) begin
      s = t / BC;
      tv_valid[s + DEPTH] = 1; tv_exp[s + DEPTH] = tbl[k].e0;
      tv_valid[s + 1 + DEPTH] = 1; tv_exp[s + 1 + DEPTH] = tbl[k].e1;
      repeat (2 * BC) begin
        u = t - s * BC;
        pin_v = (u >= tbl[k].pos && u < tbl[k].pos + tbl[k].len) ? tbl[k].mask : '0;
        tick();
      end
    end
    pin_v = '0;
    run_slots(DEPTH + 2);

    s = t / BC;
    trk_reset();
    repeat (BC) begin
      u = t % BC;
      pin_v = (u < 12 && u % 2 == 0) ? 4'b0001 : '0;
      tick();
    end
    pin_v = '0;
    run_slots(DEPTH + 1);
    chk("burst_delay", first_sig0 - s * BC, DEPTH * BC + 2);
    chk("burst_len", en_cnt[0], PC);
    chk("burst_count", rise_cnt[0], 1);
    chk("burst_others", en_cnt[1] + en_cnt[2] + en_cnt[3], 0);

    for (int w = 0; w < 36; w++) begin
      for (int i = 0; i < CH; i++) begin
        b[i] = (w < 35) ? 1'($urandom_range(0, 1)) : 1'b0;
        pos[i] = $urandom_range(0, BC - 6);
        len[i] = $urandom_range(1, 3);
      end
      repeat (BC) begin
        u = t % BC;
        for (int i = 0; i < CH; i++) pin_v[i] = b[i] && u >= pos[i] && u < pos[i] + len[i];
        tick();
      end
    end
    pin_v = '0;
    run_slots(DEPTH + 1);

    wd = 35'h5_5555_5555;
    for (int k = 0; k < DEPTH; k++) begin
      repeat (BC) begin
        u = t % BC;
        pin_v = (wd[k] && u >= 3 && u < 6) ? 4'b0100 : '0;
        tick();
      end
    end
    pin_v = '0;
    rc_v = 4'b0100;
    trk_reset();
    run_slots(3 * DEPTH);
    g = 0;
    for (int k = 0; k < DEPTH; k++) g += int'(wd[k]);
    chk("recirc_passes", rise_cnt[2], 3 * g);
    chk("recirc_others", rise_cnt[0] + rise_cnt[1] + rise_cnt[3], 0);

    repeat (BC - 4) tick();
    clr_v = 1;
    trk_reset();
    tick();
    clr_v = 0;
    repeat (3 + (DEPTH + 1) * BC) tick();
    chk("clear_busy_len", busy_cnt, DEPTH * BC);
    chk("clear_quiet", en_total(), 0);
    trk_reset();
    run_slots(2 * DEPTH);
    chk("clear_zeros", rise_cnt[2], 0);

    rc_v = '0;
    align();
    repeat (BC) begin
      u = t % BC;
      pin_v = (u >= 1 && u < 4) ? 4'b0010 : '0;
      tick();
    end
    pin_v = '0;
    g = 0;
    while (!out_en[1] && g < 3 * DEPTH * BC) begin tick(); g++; end
    chk("burst_seen", out_en[1], 1);
    tick(); tick();
    chk("mid_burst", out_en[1], 1);
    rst_n = 0;
    #1;
    chk("rst_drop", {out_sig, out_en, slot_start}, 0);
    chk("rst_busy", busy, 1);
    @(negedge clk);
    rst_n = 1;
    model_reset(); trk_reset();
    repeat (DEPTH * BC) begin
      pin_v = CH'($urandom_range(0, 15));
      tick();
    end
    pin_v = '0;
    chk("reprime_len", busy_cnt, DEPTH * BC);
    chk("reprime_quiet", en_total(), 0);
    run_slots(DEPTH + 1);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
